// File: rtl/ofd_pkg.sv
// Shared limits and helpers for the double-buffered output register bank.
package ofd_pkg;

  localparam int unsigned NCH_MAX   = 32;
  localparam int unsigned W_MAX     = 16;
  localparam int unsigned DEPTH_MAX = 4;

  // Bit offset of channel k inside a packed NCH*W vector.
  function automatic int unsigned chan_slice(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic bit params_ok(input int unsigned nch, input int unsigned w,
                                   input int unsigned depth);
    return (nch >= 1) && (nch <= NCH_MAX) && (w >= 1) && (w <= W_MAX) &&
           (depth >= 1) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/ofd_pipe.sv
// Clock-enabled register chain with async reset; zero stages degenerates to a wire.
module ofd_pipe #(
  parameter int unsigned       Width  = 1,
  parameter int unsigned       Stages = 1,
  parameter logic [Width-1:0]  RstVal = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  if (Stages == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_chain
    logic [Width-1:0] stage_q [Stages];

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        for (int i = 0; i < Stages; i++) stage_q[i] <= RstVal;
      end else if (ce) begin
        stage_q[0] <= din;
        for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[Stages-1];
  end

endmodule

// File: rtl/ofd_bank.sv
// Double-buffered output register bank: masked shadow load, atomic commit, retimed Q
// and a commit-acknowledge that rises together with the new Q.
module ofd_bank
  import ofd_pkg::*;
#(
  parameter int unsigned         NCH   = 4,
  parameter int unsigned         W     = 1,
  parameter int unsigned         DEPTH = 1,
  parameter logic [NCH*W-1:0]    INIT  = '0
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             CE,
  input  logic [NCH*W-1:0] D,
  input  logic [NCH-1:0]   WMASK,
  input  logic             LD,
  input  logic             UPD,
  output logic [NCH*W-1:0] Q,
  output logic             PEND,
  output logic             ACK
);

  localparam int unsigned NW = NCH * W;

  if (!params_ok(NCH, W, DEPTH)) begin : g_param_check
    $fatal(1, "ofd_bank: NCH, W or DEPTH out of range");
  end

  logic [NW-1:0] shadow_q, commit_q, commit_d, merged;
  logic          pend_q, pend_d;

  // Shadow with this cycle's masked write applied; also the commit source so that
  // a same-cycle LD+UPD commits the new data.
  always_comb begin
    merged = shadow_q;
    if (LD) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (WMASK[k]) merged[chan_slice(k, W) +: W] = D[chan_slice(k, W) +: W];
      end
    end
  end

  always_comb begin
    commit_d = UPD ? merged : commit_q;
    pend_d   = pend_q;
    if (UPD)                  pend_d = 1'b0;
    else if (LD && |WMASK)    pend_d = 1'b1;
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      shadow_q <= INIT;
      commit_q <= INIT;
      pend_q   <= 1'b0;
    end else if (CE) begin
      shadow_q <= merged;
      commit_q <= commit_d;
      pend_q   <= pend_d;
    end
  end

  ofd_pipe #(
    .Width  (NW),
    .Stages (DEPTH - 1),
    .RstVal (INIT)
  ) u_data_pipe (
    .clk  (CK),
    .clr  (CLR),
    .ce   (CE),
    .din  (commit_q),
    .dout (Q)
  );

  ofd_pipe #(
    .Width  (1),
    .Stages (DEPTH),
    .RstVal (1'b0)
  ) u_token_pipe (
    .clk  (CK),
    .clr  (CLR),
    .ce   (CE),
    .din  (UPD),
    .dout (ACK)
  );

  assign PEND = pend_q;

endmodule

// File: tb/tb_ofd_bank.sv
// Bench for ofd_bank: four instances (DEPTH 1..4) share stimulus; commits are queued
// and retired against each instance's ACK at its expected CE-cycle.
module tb_ofd_bank;

  localparam int NDUT = 4;
  localparam logic [7:0] INIT = 8'hA5;

  logic       ck = 1'b0;
  logic       clr, ce, ld, upd;
  logic [7:0] d;
  logic [3:0] wmask;

  logic [7:0] q_w    [NDUT];
  logic       pend_w [NDUT];
  logic       ack_w  [NDUT];

  always #5 ck = ~ck;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ofd_bank #(
      .NCH   (4),
      .W     (2),
      .DEPTH (g + 1),
      .INIT  (INIT)
    ) u_dut (
      .CK    (ck),
      .CLR   (clr),
      .CE    (ce),
      .D     (d),
      .WMASK (wmask),
      .LD    (ld),
      .UPD   (upd),
      .Q     (q_w[g]),
      .PEND  (pend_w[g]),
      .ACK   (ack_w[g])
    );
  end

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  int         rd      [NDUT];
  logic [7:0] exp_q   [NDUT];
  logic       exp_ack [NDUT];
  logic [7:0] s_m;
  logic       pend_m;
  int         cyc;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int g = 0; g < NDUT; g++) begin
      rd[g]      = 0;
      exp_q[g]   = INIT;
      exp_ack[g] = 1'b0;
    end
    s_m    = INIT;
    pend_m = 1'b0;
  endtask

  task automatic check_outputs();
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("q_depth%0d", g + 1), {24'd0, q_w[g]}, {24'd0, exp_q[g]});
      check_eq($sformatf("ack_depth%0d", g + 1), {31'd0, ack_w[g]}, {31'd0, exp_ack[g]});
      check_eq($sformatf("pend_depth%0d", g + 1), {31'd0, pend_w[g]}, {31'd0, pend_m});
    end
  endtask

  // One clock: drive inputs, update the model on a CE edge, then compare outputs.
  task automatic step(input logic [7:0] di, input logic [3:0] mi, input logic li,
                      input logic ui, input logic ci);
    logic [7:0] m;
    int         lo;
    d = di; wmask = mi; ld = li; upd = ui; ce = ci;
    @(posedge ck);
    #1;
    if (ci) begin
      cyc++;
      m = s_m;
      if (li) begin
        for (int k = 0; k < 4; k++) if (mi[k]) m[2*k +: 2] = di[2*k +: 2];
      end
      if (ui) begin
        sb.push_back('{data: m, cyc: cyc});
        pend_m = 1'b0;
      end else if (li && mi != 4'd0) begin
        pend_m = 1'b1;
      end
      s_m = m;
      for (int g = 0; g < NDUT; g++) begin
        exp_ack[g] = 1'b0;
        if (rd[g] < sb.size() && sb[rd[g]].cyc + g == cyc) begin
          exp_q[g]   = sb[rd[g]].data;
          exp_ack[g] = 1'b1;
          rd[g]++;
        end
      end
      lo = rd[0];
      for (int g = 1; g < NDUT; g++) if (rd[g] < lo) lo = rd[g];
      for (int i = 0; i < lo; i++) begin
        void'(sb.pop_front());
        for (int g = 0; g < NDUT; g++) rd[g]--;
      end
    end
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Async reset applied between edges; outputs must reflect it without a clock.
  task automatic pulse_clr();
    #2 clr = 1'b1;
    #1 model_reset();
    check_outputs();
    #1 clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; ce = 1'b0; ld = 1'b0; upd = 1'b0; d = 8'h00; wmask = 4'h0;
    cyc = 0;
    #2 model_reset();
    check_outputs();
    #1 clr = 1'b0;

    // Masked load, then commit on the following cycle.
    step(8'hFF, 4'b0101, 1'b1, 1'b0, 1'b1);
    step(8'h00, 4'b0000, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Same-cycle load and commit.
    step(8'h3C, 4'b1111, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Back-to-back commits.
    step(8'h01, 4'b1111, 1'b1, 1'b1, 1'b1);
    step(8'h02, 4'b1111, 1'b1, 1'b1, 1'b1);
    step(8'h03, 4'b1111, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Zero-mask load is a no-op; commit with nothing pending still acknowledges.
    step(8'hAA, 4'b0000, 1'b1, 1'b0, 1'b1);
    step(8'h00, 4'b0000, 1'b0, 1'b1, 1'b1);
    idle(4);

    // CE freeze with a commit in flight; LD/UPD must be ignored while frozen.
    step(8'h5A, 4'b1111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'hFF, 4'b1111, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Load pending, then frozen, to show PEND holds.
    step(8'h96, 4'b0011, 1'b1, 1'b0, 1'b1);
    step(8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(8'h00, 4'b0000, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Reset mid-flight: the commit must never be acknowledged.
    step(8'hC3, 4'b1111, 1'b1, 1'b1, 1'b1);
    step(8'h00, 4'b0000, 1'b0, 1'b0, 1'b1);
    pulse_clr();
    idle(5);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
